// File: rtl/issue_sched.sv
// Tomasulo issue-stage scheduler: ROB head/tail and completion tracking, per-class RS occupancy, in-order retire.
// Optional stall statistics (stall_rob / stall_rs) are built when ISSUE_SCHED_STATS_EN is defined.
module issue_sched #(
    parameter int ROB_DEPTH = 8,
    parameter int PTR_W     = 3,
    parameter int RS_SLOTS  = 3
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [3:0]       iss_func,
    input  logic [3:0]       iss_rd,
    output logic             iss_grant,
    output logic [PTR_W-1:0] iss_tag,
    output logic             iss_illegal,
    input  logic             rs_rel_add,
    input  logic             rs_rel_mul,
    input  logic             rs_rel_bch,
    input  logic             cdb_valid,
    input  logic [PTR_W-1:0] cdb_tag,
    input  logic             commit_ready,
    output logic             commit_valid,
    output logic [PTR_W-1:0] commit_tag,
    output logic [3:0]       commit_rd,
    input  logic             flush,
    output logic [PTR_W:0]   rob_count,
    output logic             rob_full,
    output logic             rob_empty,
    output logic [1:0]       add_cnt,
    output logic [1:0]       mul_cnt,
    output logic [1:0]       bch_cnt
`ifdef ISSUE_SCHED_STATS_EN
    ,
    output logic [15:0]      stall_rob,
    output logic [15:0]      stall_rs
`endif
);

    typedef enum logic [1:0] {
        CLS_ADD  = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_BCH  = 2'd2,
        CLS_NONE = 2'd3
    } iss_cls_e;

    localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(ROB_DEPTH);
    localparam logic [1:0]     SLOTS_MAX = 2'(RS_SLOTS);

    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;
    logic             r_done   [ROB_DEPTH];
    logic [3:0]       r_func   [ROB_DEPTH];
    logic [3:0]       r_rd     [ROB_DEPTH];
    logic [1:0]       r_rs_cnt [3];

    logic [PTR_W-1:0] w_head_idx;
    logic [PTR_W-1:0] w_tail_idx;
    logic [PTR_W-1:0] w_cdb_off;
    logic [PTR_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_legal;
    logic             w_cdb_hit;
    logic             w_commit;
    iss_cls_e         w_cls;
    logic [1:0]       w_cls_cnt;
    logic [2:0]       w_alloc;
    logic [2:0]       w_rel;
    logic [2:0]       w_dec;
    logic [1:0]       w_rs_cnt_nxt [3];
    logic             w_unused_func;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_count    = r_tail - r_head;
    assign w_full     = (w_count == DEPTH_CNT);
    assign w_empty    = (w_count == '0);

    // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        w_cls     = CLS_NONE;
        w_cls_cnt = SLOTS_MAX;
        case (iss_func)
            4'h0, 4'h1: w_cls = CLS_ADD;
            4'h2, 4'h3: w_cls = CLS_MUL;
            4'h4, 4'h5: w_cls = CLS_BCH;
            default:    w_cls = CLS_NONE;
        endcase
        case (w_cls)
            CLS_ADD: w_cls_cnt = r_rs_cnt[0];
            CLS_MUL: w_cls_cnt = r_rs_cnt[1];
            CLS_BCH: w_cls_cnt = r_rs_cnt[2];
            default: w_cls_cnt = SLOTS_MAX;
        endcase
    end

    assign w_legal     = (w_cls != CLS_NONE);
    assign iss_grant   = iss_valid & w_legal & ~w_full & (w_cls_cnt < SLOTS_MAX) & ~flush;
    assign iss_tag     = w_tail_idx;
    assign iss_illegal = iss_valid & ~w_legal;

    // A CDB tag counts only if its distance from head falls inside the occupied window.
    assign w_cdb_off = cdb_tag - w_head_idx;
    assign w_cdb_hit = cdb_valid & ({1'b0, w_cdb_off} < w_count);

    assign commit_valid = r_done[w_head_idx] & ~w_empty & ~flush;
    assign w_commit     = commit_valid & commit_ready;
    assign commit_tag   = w_head_idx;
    assign commit_rd    = r_rd[w_head_idx];
    // func travels with the entry for downstream consumers; nothing in this block reads it.
    assign w_unused_func = ^r_func[w_head_idx];

    assign rob_count = w_count;
    assign rob_full  = w_full;
    assign rob_empty = w_empty;

    assign w_rel = {rs_rel_bch, rs_rel_mul, rs_rel_add};

    always_comb begin
        w_alloc = '0;
        if (iss_grant) begin
            case (w_cls)
                CLS_ADD: w_alloc[0] = 1'b1;
                CLS_MUL: w_alloc[1] = 1'b1;
                CLS_BCH: w_alloc[2] = 1'b1;
                default: w_alloc = '0;
            endcase
        end
    end

    // Releases on an empty class are dropped; a paired grant and release cancel out.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_dec[i]        = w_rel[i] & (r_rs_cnt[i] != 2'd0);
            w_rs_cnt_nxt[i] = r_rs_cnt[i];
            if (w_alloc[i] && !w_dec[i]) begin
                w_rs_cnt_nxt[i] = r_rs_cnt[i] + 2'd1;
            end else if (!w_alloc[i] && w_dec[i]) begin
                w_rs_cnt_nxt[i] = r_rs_cnt[i] - 2'd1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments; where commit and grant both touch r_done, the later write wins.
    // NOTE: the ROB payload must read back as zero after reset, so it sits in async-reset flops, not a RAM.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_done[i] <= 1'b0;
                r_func[i] <= '0;
                r_rd[i]   <= '0;
            end
        end else if (flush) begin
            r_tail <= r_head;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_done[i] <= 1'b0;
            end
        end else begin
            if (w_cdb_hit) begin
                r_done[cdb_tag] <= 1'b1;
            end
            if (w_commit) begin
                r_head             <= r_head + PTR_ONE;
                r_done[w_head_idx] <= 1'b0;
            end
            if (iss_grant) begin
                r_tail             <= r_tail + PTR_ONE;
                r_func[w_tail_idx] <= iss_func;
                r_rd[w_tail_idx]   <= iss_rd;
                r_done[w_tail_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_rs_cnt[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < 3; i++) begin
                r_rs_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_rs_cnt[i] <= w_rs_cnt_nxt[i];
            end
        end
    end

    assign add_cnt = r_rs_cnt[0];
    assign mul_cnt = r_rs_cnt[1];
    assign bch_cnt = r_rs_cnt[2];

`ifdef ISSUE_SCHED_STATS_EN
    logic [15:0] r_stall_rob;
    logic [15:0] r_stall_rs;
    logic        w_stall_rob;
    logic        w_stall_rs;

    // A ROB-full stall takes precedence; the RS stall is counted only when the ROB had room.
    assign w_stall_rob = iss_valid & w_legal & w_full & ~flush;
    assign w_stall_rs  = iss_valid & w_legal & ~w_full & (w_cls_cnt == SLOTS_MAX) & ~flush;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_rob <= '0;
            r_stall_rs  <= '0;
        end else begin
            if (w_stall_rob && (r_stall_rob != 16'hFFFF)) begin
                r_stall_rob <= r_stall_rob + 16'd1;
            end
            if (w_stall_rs && (r_stall_rs != 16'hFFFF)) begin
                r_stall_rs <= r_stall_rs + 16'd1;
            end
        end
    end

    assign stall_rob = r_stall_rob;
    assign stall_rs  = r_stall_rs;
`endif

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed scenarios plus random traffic against a queue-based ROB model;
// a separate monitor checks every retire against a scoreboard of granted {tag, rd}.
module tb_issue_sched;

    localparam int ROB_DEPTH = 8;
    localparam int PTR_W     = 3;
    localparam int RS_SLOTS  = 3;

    logic             clk1 = 1'b0;
    logic             rst_n;
    logic             iss_valid;
    logic [3:0]       iss_func;
    logic [3:0]       iss_rd;
    logic             iss_grant;
    logic [PTR_W-1:0] iss_tag;
    logic             iss_illegal;
    logic             rs_rel_add;
    logic             rs_rel_mul;
    logic             rs_rel_bch;
    logic             cdb_valid;
    logic [PTR_W-1:0] cdb_tag;
    logic             commit_ready;
    logic             commit_valid;
    logic [PTR_W-1:0] commit_tag;
    logic [3:0]       commit_rd;
    logic             flush;
    logic [PTR_W:0]   rob_count;
    logic             rob_full;
    logic             rob_empty;
    logic [1:0]       add_cnt;
    logic [1:0]       mul_cnt;
    logic [1:0]       bch_cnt;
`ifdef ISSUE_SCHED_STATS_EN
    logic [15:0]      stall_rob;
    logic [15:0]      stall_rs;
`endif

    issue_sched #(.ROB_DEPTH(ROB_DEPTH), .PTR_W(PTR_W), .RS_SLOTS(RS_SLOTS)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_func(iss_func), .iss_rd(iss_rd),
        .iss_grant(iss_grant), .iss_tag(iss_tag), .iss_illegal(iss_illegal),
        .rs_rel_add(rs_rel_add), .rs_rel_mul(rs_rel_mul), .rs_rel_bch(rs_rel_bch),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .commit_ready(commit_ready), .commit_valid(commit_valid),
        .commit_tag(commit_tag), .commit_rd(commit_rd),
        .flush(flush), .rob_count(rob_count), .rob_full(rob_full), .rob_empty(rob_empty),
        .add_cnt(add_cnt), .mul_cnt(mul_cnt), .bch_cnt(bch_cnt)
`ifdef ISSUE_SCHED_STATS_EN
        , .stall_rob(stall_rob), .stall_rs(stall_rs)
`endif
    );

    always #5 clk1 = ~clk1;

    typedef struct { int tag; int rd; bit done; } rob_ent_t;
    typedef struct { int tag; int rd; } retire_t;

    rob_ent_t m_rob[$];
    retire_t  sb_q[$];
    int       m_next_tag;
    int       m_cnt[3];
    int       n_checks;
    int       n_fail;
`ifdef ISSUE_SCHED_STATS_EN
    int       m_stall_rob;
    int       m_stall_rs;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rob.delete();
        sb_q.delete();
        m_next_tag = 0;
        m_cnt = '{0, 0, 0};
`ifdef ISSUE_SCHED_STATS_EN
        m_stall_rob = 0;
        m_stall_rs  = 0;
`endif
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_func = 4'h0; iss_rd = 4'h0;
        rs_rel_add = 1'b0; rs_rel_mul = 1'b0; rs_rel_bch = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; commit_ready = 1'b0; flush = 1'b0;
    endtask

    // Reset asserted between edges; state must clear immediately.
    task automatic do_reset();
        @(negedge clk1);
        drive_idle();
        #3 rst_n = 1'b0;
        #1;
        check("rst_rob_empty", rob_empty, 1);
        check("rst_rob_full", rob_full, 0);
        check("rst_rob_count", rob_count, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_iss_grant", iss_grant, 0);
        check("rst_commit_tag", commit_tag, 0);
        check("rst_cnts", {add_cnt, mul_cnt, bch_cnt}, 0);
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: drive, compare against the model, then advance the model at the edge.
    task automatic cycle(input bit v, input int f, input int rd, input bit ra, input bit rm, input bit rb,
                         input bit cv, input int ct, input bit rdy, input bit fl);
        bit legal, full, grant, cvld, cls_full;
        int cls, head_tag;
        bit rel[3];
        @(negedge clk1);
        iss_valid = v; iss_func = 4'(f); iss_rd = 4'(rd);
        rs_rel_add = ra; rs_rel_mul = rm; rs_rel_bch = rb;
        cdb_valid = cv; cdb_tag = PTR_W'(ct); commit_ready = rdy; flush = fl;
        #1;
        rel      = '{ra, rm, rb};
        legal    = (f <= 5);
        cls      = legal ? f / 2 : 0;
        full     = (m_rob.size() == ROB_DEPTH);
        cls_full = legal && (m_cnt[cls] >= RS_SLOTS);
        grant    = v && legal && !full && !cls_full && !fl;
        head_tag = (m_rob.size() > 0) ? m_rob[0].tag : m_next_tag;
        cvld     = (m_rob.size() > 0) && m_rob[0].done && !fl;
        check("iss_grant", iss_grant, grant);
        if (grant) check("iss_tag", iss_tag, m_next_tag);
        check("iss_illegal", iss_illegal, v && !legal);
        check("commit_valid", commit_valid, cvld);
        check("commit_tag", commit_tag, head_tag);
        check("rob_count", rob_count, m_rob.size());
        check("rob_full", rob_full, full);
        check("rob_empty", rob_empty, m_rob.size() == 0);
        check("add_cnt", add_cnt, m_cnt[0]);
        check("mul_cnt", mul_cnt, m_cnt[1]);
        check("bch_cnt", bch_cnt, m_cnt[2]);
`ifdef ISSUE_SCHED_STATS_EN
        check("stall_rob", stall_rob, m_stall_rob);
        check("stall_rs", stall_rs, m_stall_rs);
`endif
        @(posedge clk1);
`ifdef ISSUE_SCHED_STATS_EN
        if (v && legal && !fl) begin
            if (full) begin
                if (m_stall_rob < 65535) m_stall_rob++;
            end else if (cls_full) begin
                if (m_stall_rs < 65535) m_stall_rs++;
            end
        end
`endif
        if (fl) begin
            m_rob.delete();
            sb_q.delete();
            m_cnt = '{0, 0, 0};
            m_next_tag = head_tag;
        end else begin
            if (cv) begin
                foreach (m_rob[i]) if (m_rob[i].tag == ct) m_rob[i].done = 1'b1;
            end
            if (cvld && rdy) void'(m_rob.pop_front());
            if (grant) begin
                m_rob.push_back('{tag: m_next_tag, rd: rd, done: 1'b0});
                sb_q.push_back('{tag: m_next_tag, rd: rd});
                m_next_tag = (m_next_tag + 1) % ROB_DEPTH;
            end
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = m_cnt[i] + ((grant && cls == i) ? 1 : 0) - ((rel[i] && m_cnt[i] > 0) ? 1 : 0);
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input int f, input int rd);
        cycle(1, f, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cdb(input int t);
        cycle(0, 0, 0, 0, 0, 0, 1, t, 0, 0);
    endtask

    // Retire monitor: independent of the driver, pops the scoreboard whenever the DUT retires.
    initial begin
        retire_t r;
        forever begin
            @(negedge clk1);
            #2;
            if (rst_n === 1'b1 && commit_valid === 1'b1 && commit_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_retire: retire of tag %0d with nothing outstanding", commit_tag);
                end else begin
                    r = sb_q.pop_front();
                    check("sb_commit_tag", commit_tag, r.tag);
                    check("sb_commit_rd", commit_rd, r.rd);
                end
            end
        end
    end

    initial begin
        int v, f, ct;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive_idle();
        model_reset();
        #12;
        rst_n = 1'b1;

        // Basic issue
        do_reset();
        issue(0, 5);
        idle();

        // RS class full, then release
        do_reset();
        issue(0, 1); issue(1, 2); issue(0, 3); issue(1, 4);
        cycle(1, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        issue(0, 4);
        idle();

        // ROB full and wrap
        do_reset();
        for (int i = 0; i < ROB_DEPTH; i++) cycle(1, i % 6, i + 1, 1, 1, 1, 0, 0, 0, 0);
        issue(2, 9);
        cdb(0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        issue(4, 10);
        idle();

        // Out-of-order completion
        do_reset();
        issue(0, 7); issue(2, 8); issue(4, 9);
        cdb(2); cdb(1); idle();
        cdb(0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Simultaneous grant/commit/release, then out-of-window CDB
        do_reset();
        issue(2, 1); issue(3, 2); issue(0, 3); issue(1, 4);
        cdb(0);
        cycle(1, 2, 5, 0, 1, 0, 0, 0, 1, 0);
        cdb(6);
        idle();

        // Flush with pending issue, then illegal opcode
        do_reset();
        for (int i = 0; i < 5; i++) issue(i, i + 2);
        cdb(1);
        cycle(1, 0, 3, 0, 0, 0, 1, 0, 1, 1);
        idle();
        issue(15, 3);
        issue(6, 3);
        issue(0, 11);
        idle();

        // Random traffic, with one asynchronous reset in the middle
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            f  = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 5) : $urandom_range(6, 15);
            ct = (m_rob.size() > 0 && $urandom_range(0, 9) < 7)
                 ? m_rob[$urandom_range(0, m_rob.size() - 1)].tag : $urandom_range(0, 7);
            cycle(v[0], f, $urandom_range(0, 15),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 6, ct, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        // Drain within a bounded number of cycles
        for (int k = 0; k < 64 && m_rob.size() > 0; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, m_rob[0].tag, 1, 0);
        end
        idle();
        check("drain_rob_empty", rob_empty, 1);
        check("drain_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Scheduler and resource controller for the Tomasulo issue stage.
- Owns ROB head/tail pointers, per-entry completion bits and per-class reservation-station occupancy counters (add, mul, branch).
- Grants or stalls each issue request, returns the allocated ROB tag, marks entries done from the CDB, and retires the ROB head in order.
- Sits between the decode/issue front end, the reservation stations (Rstation_append) and the CDB/commit path.

Parameters:
- ROB_DEPTH, 8: number of ROB entries; power of two.
- PTR_W, 3: log2(ROB_DEPTH); width of a ROB tag.
- RS_SLOTS, 3: reservation-station slots per class.

Ports:
- clk1, input, 1: clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- iss_valid, input, 1: issue request.
- iss_func, input, 4: opcode. 0000/0001 = add class; 0010/0011 = mul class; 0100/0101 = branch class; all other values illegal.
- iss_rd, input, 4: destination register.
- iss_grant, output, 1: combinational; the request is accepted this cycle.
- iss_tag, output, PTR_W: combinational; tail tag allocated on grant.
- iss_illegal, output, 1: combinational; iss_valid with an illegal func.
- rs_rel_add, rs_rel_mul, rs_rel_bch, input, 1 each: one RS slot of that class freed this cycle.
- cdb_valid, input, 1: result broadcast.
- cdb_tag, input, PTR_W: ROB tag that completed.
- commit_ready, input, 1: register file can accept a retire.
- commit_valid, output, 1: combinational; head is done and ROB is not empty.
- commit_tag, output, PTR_W: head tag.
- commit_rd, output, 4: rd stored at head.
- flush, input, 1: synchronous squash.
- rob_count, output, PTR_W+1: occupied entries.
- rob_full, output, 1.
- rob_empty, output, 1.
- add_cnt, mul_cnt, bch_cnt, output, 2 each: RS occupancy per class.

Behaviour:
- **Reset (async, rst_n low):**
  - head = tail = 0; all done bits = 0; all class counters = 0.
  - rob_empty = 1; rob_full = 0; rob_count = 0; commit_valid = 0; iss_grant = 0.
  - Stored func/rd fields are cleared to 0.
- **Pointers:**
  - head and tail are PTR_W+1 bits wide; the low PTR_W bits index the ROB and wrap modulo ROB_DEPTH.
  - rob_count = tail - head (modulo 2^(PTR_W+1)).
  - rob_full when rob_count == ROB_DEPTH; all 8 entries are usable.
  - rob_empty when rob_count == 0.
- **Grant:** iss_grant = iss_valid & legal func & !rob_full & class counter < RS_SLOTS & !flush.
  - Evaluated on registered state only; a same-cycle commit or rs_rel does not bypass into grant.
- **On grant, at the clock edge:**
  - ROB[tail] ← {func, rd}; done[tail] ← 0; tail increments.
  - The class counter increments.
  - iss_tag = tail[PTR_W-1:0] during the grant cycle (zero latency).
- **Illegal func:** no allocation; iss_illegal = 1 while iss_valid is high.
- **RS release:** rs_rel_x decrements counter x.
  - Release and grant for the same class in the same cycle leave the counter unchanged.
  - Release while the counter is 0 is ignored; the counter saturates at 0.
- **CDB:** cdb_valid sets done[cdb_tag] only if the tag lies in [head, tail); otherwise ignored.
  - A CDB hit on the head makes commit_valid rise the next cycle. There is no bypass.
- **Commit:** commit_valid = done[head] & !rob_empty.
  - When commit_valid & commit_ready: at the edge head increments and done[head] is cleared.
  - At most one retire per cycle.
- **Simultaneous events:**
  - Grant and commit in the same cycle: both take effect; rob_count is unchanged.
  - Grant while full with a same-cycle commit: grant stays 0.
- **Flush (highest priority, synchronous):**
  - tail ← head; all done bits ← 0; all class counters ← 0.
  - Same-cycle grant, CDB and commit are suppressed.
  - commit_valid is forced to 0 during the flush cycle.
- **Reset mid-operation:** immediate return to reset state regardless of in-flight entries.

Optional Feature:
- Macro: ISSUE_SCHED_STATS_EN.
- **When defined:** adds outputs stall_rob (16 bits) and stall_rs (16 bits), both saturating at 16'hFFFF and cleared by rst_n.
  - stall_rob increments each cycle with iss_valid, a legal func and rob_full.
  - Otherwise, stall_rs increments each cycle with iss_valid, a legal func and the class counter at RS_SLOTS.
  - Neither counter changes on flush.
- **When undefined:** these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- **Reset and basic issue:** reset, then issue func=0000 rd=5.
  - iss_grant=1, iss_tag=0.
  - Next cycle: rob_count=1, add_cnt=1, rob_empty=0.
- **RS class full:** issue 4 consecutive add ops with no release.
  - First 3 granted with tags 0, 1, 2; 4th has iss_grant=0 and add_cnt=3.
  - Pulse rs_rel_add: 4th granted next cycle with tag 3.
- **ROB full and wrap:** issue 8 ops mixed across classes, with releases so RS never blocks.
  - rob_full=1 and the 9th is stalled.
  - CDB tag 0, then commit_ready=1: commit_tag=0 retires, rob_full=0.
  - Next issue gets tag 0 (wrap); rob_count=8.
- **Out-of-order completion:** tags 0–2 allocated; CDB tag 2, then tag 1.
  - commit_valid stays 0.
  - CDB tag 0: commits 0, 1, 2 on consecutive cycles; commit_rd matches the issued rd values.
- **Simultaneous events:** at count 4, grant + commit + rs_rel_mul (mul_cnt=2) + mul grant in one cycle.
  - rob_count stays 4, mul_cnt stays 2.
  - CDB to an unallocated tag 6: no change.
- **Flush and illegal func:** with 5 entries, assert flush together with iss_valid.
  - Next cycle: rob_empty=1, all class counters 0, no grant.
  - iss_func=1111: iss_illegal=1, iss_grant=0, rob_count unchanged.
